phase_generator_mc: RTL and testbench

//  Multi-channel, time-multiplexed phase accumulator (NCO core) for the APU voice path.
//  One shared adder serves NUM_CHANNELS voices. Per-channel phase and delta are held in register arrays.

---
 rtl/phase_generator_mc.sv | 101 ++++++++++
 tb/tb_phase_generator_mc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_generator_mc.sv
// Time-multiplexed NCO phase accumulator: one shared adder sweeps every voice once per
// sample tick and streams each channel's updated phase/wrap to the waveform lookup stage.
module phase_generator_mc #(
  parameter int NUM_CHANNELS = 4,
  parameter int PHASE_WIDTH  = 32,
  parameter int CH_WIDTH     = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_tick,
  input  logic                   i_wr_en,
  input  logic [CH_WIDTH-1:0]    i_wr_ch,
  input  logic [PHASE_WIDTH-1:0] i_wr_delta,
  input  logic                   i_phase_clr,
  output logic [PHASE_WIDTH-1:0] o_phase,
  output logic [CH_WIDTH-1:0]    o_phase_ch,
  output logic                   o_phase_valid,
  output logic                   o_phase_wrap,
  output logic                   o_busy,
  output logic                   o_overrun
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(NUM_CHANNELS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                 state;
  logic [CH_WIDTH-1:0]    idx;
  logic [PHASE_WIDTH-1:0] phase [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] delta [NUM_CHANNELS];
  logic [PHASE_WIDTH:0]   sum;
  logic [IDX_W-1:0]       wr_sel;
  logic [IDX_W-1:0]       cur_sel;
  logic                   wr_ok;
  logic                   clr_hit;

  // Channel indices wider than the register arrays only address real voices when in range.
  assign wr_sel  = i_wr_ch[IDX_W-1:0];
  assign cur_sel = idx[IDX_W-1:0];
  assign wr_ok   = ({1'b0, i_wr_ch} < (CH_WIDTH + 1)'(NUM_CHANNELS));
  assign sum     = {1'b0, phase[cur_sel]} + {1'b0, delta[cur_sel]};
  assign clr_hit = wr_ok && i_phase_clr && (i_wr_ch == idx);
  assign o_busy  = (state == SWEEP);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      idx           <= '0;
      o_phase       <= '0;
      o_phase_ch    <= '0;
      o_phase_valid <= 1'b0;
      o_phase_wrap  <= 1'b0;
      o_overrun     <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        phase[i] <= '0;
        delta[i] <= '0;
      end
    end else begin
      o_phase_valid <= 1'b0;
      o_overrun     <= 1'b0;

      case (state)
        IDLE: begin
          if (i_tick) begin
            state <= SWEEP;
            idx   <= '0;
          end
        end
        SWEEP: begin
          // A key-on clear on the channel being accumulated overrides the new sum.
          if (clr_hit) begin
            phase[cur_sel] <= '0;
            o_phase        <= '0;
            o_phase_wrap   <= 1'b0;
          end else begin
            phase[cur_sel] <= sum[PHASE_WIDTH-1:0];
            o_phase        <= sum[PHASE_WIDTH-1:0];
            o_phase_wrap   <= sum[PHASE_WIDTH];
          end
          o_phase_ch    <= idx;
          o_phase_valid <= 1'b1;

          if (idx == LAST_CH) begin
            idx <= '0;
            if (!i_tick) state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
            if (i_tick) o_overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Delta writes land after the accumulate read, so a same-cycle write uses the old delta.
      if (wr_ok && i_wr_en)     delta[wr_sel] <= i_wr_delta;
      if (wr_ok && i_phase_clr) phase[wr_sel] <= '0;
    end
  end

endmodule

// File: tb/tb_phase_generator_mc.sv
// Bench for phase_generator_mc: two builds (CH_WIDTH 2 and 3) share stimulus and are
// compared every cycle against a schedule-based model, plus literal directed checks.
module tb_phase_generator_mc;

  localparam int N = 4;

  logic        i_clk = 1'b0;
  logic        i_rst, tick, wr_en, clr;
  logic [2:0]  wr_ch;
  logic [31:0] wr_delta;

  logic [31:0] a_phase, b_phase;
  logic [1:0]  a_ch;
  logic [2:0]  b_ch;
  logic        a_valid, a_wrap, a_busy, a_ovr;
  logic        b_valid, b_wrap, b_busy, b_ovr;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  longint unsigned m_phase [2][N];
  longint unsigned m_delta [2][N];
  int              m_start = -100;
  int              edge_n  = 0;
  logic [31:0]     e_phase [2];
  logic            e_wrap  [2];
  int              e_ch;
  logic            e_valid, e_busy, e_ovr;

  phase_generator_mc #(.NUM_CHANNELS(4), .PHASE_WIDTH(32), .CH_WIDTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(tick), .i_wr_en(wr_en), .i_wr_ch(wr_ch[1:0]),
    .i_wr_delta(wr_delta), .i_phase_clr(clr), .o_phase(a_phase), .o_phase_ch(a_ch),
    .o_phase_valid(a_valid), .o_phase_wrap(a_wrap), .o_busy(a_busy), .o_overrun(a_ovr)
  );

  phase_generator_mc #(.NUM_CHANNELS(4), .PHASE_WIDTH(32), .CH_WIDTH(3)) dut_w (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(tick), .i_wr_en(wr_en), .i_wr_ch(wr_ch),
    .i_wr_delta(wr_delta), .i_phase_clr(clr), .o_phase(b_phase), .o_phase_ch(b_ch),
    .o_phase_valid(b_valid), .o_phase_wrap(b_wrap), .o_busy(b_busy), .o_overrun(b_ovr)
  );

  initial forever #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A sweep accepted at edge S processes channel k at edge S+1+k; everything follows from that.
  task automatic modelStep(input bit r, input bit t, input bit we, input logic [2:0] ch3,
                           input logic [31:0] d, input bit c);
    int e;
    int cur;
    edge_n++;
    e = edge_n;
    if (r) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < N; k++) begin
          m_phase[m][k] = 0;
          m_delta[m][k] = 0;
        end
        e_phase[m] = 0;
        e_wrap[m]  = 0;
      end
      m_start = -100;
      e_ch    = 0;
      e_valid = 0;
      e_busy  = 0;
      e_ovr   = 0;
      return;
    end
    cur = e - m_start - 1;
    if (cur < 0 || cur >= N) cur = -1;
    e_ovr = 0;
    if (t) begin
      if (cur == -1 || cur == N - 1) m_start = e;
      else e_ovr = 1;
    end
    e_valid = (cur >= 0);
    if (cur >= 0) e_ch = cur;
    for (int m = 0; m < 2; m++) begin
      int chm;
      bit ok;
      longint unsigned s;
      chm = (m == 0) ? int'(ch3[1:0]) : int'(ch3);
      ok  = (chm < N);
      if (cur >= 0) begin
        if (ok && c && chm == cur) begin
          m_phase[m][cur] = 0;
          e_phase[m] = 0;
          e_wrap[m]  = 0;
        end else begin
          s = m_phase[m][cur] + m_delta[m][cur];
          e_wrap[m]       = ((s >> 32) != 0);
          m_phase[m][cur] = s & 64'hFFFF_FFFF;
          e_phase[m]      = 32'(m_phase[m][cur]);
        end
      end
      if (ok && we) m_delta[m][chm] = longint'(d);
      if (ok && c)  m_phase[m][chm] = 0;
    end
    e_busy = ((e - m_start) >= 0) && ((e - m_start) < N);
  endtask

  task automatic applyStimulus(input bit r, input bit t, input bit we, input logic [2:0] ch,
                               input logic [31:0] d, input bit c);
    @(negedge i_clk);
    i_rst = r; tick = t; wr_en = we; wr_ch = ch; wr_delta = d; clr = c;
    modelStep(r, t, we, ch, d, c);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 3'd0, 32'd0, 0);
  endtask

  task automatic settle();
    @(posedge i_clk);
    #1;
  endtask

  always @(posedge i_clk) begin
    #1;
    if (cmp_en) begin
      checkOutput("a_valid", a_valid, e_valid);
      checkOutput("a_busy",  a_busy,  e_busy);
      checkOutput("a_ovr",   a_ovr,   e_ovr);
      checkOutput("a_ch",    a_ch,    e_ch[1:0]);
      checkOutput("a_phase", a_phase, e_phase[0]);
      checkOutput("a_wrap",  a_wrap,  e_wrap[0]);
      checkOutput("b_valid", b_valid, e_valid);
      checkOutput("b_busy",  b_busy,  e_busy);
      checkOutput("b_ovr",   b_ovr,   e_ovr);
      checkOutput("b_ch",    b_ch,    e_ch[2:0]);
      checkOutput("b_phase", b_phase, e_phase[1]);
      checkOutput("b_wrap",  b_wrap,  e_wrap[1]);
    end
  end

  logic [31:0] exp1 [4];

  initial begin
    exp1[0] = 32'h4000_0000; exp1[1] = 32'h8000_0000;
    exp1[2] = 32'hC000_0000; exp1[3] = 32'h0000_0000;

    applyStimulus(1, 0, 0, 3'd0, 32'd0, 0);
    cmp_en = 1'b1;
    applyStimulus(1, 0, 0, 3'd0, 32'd0, 0);
    settle();
    checkOutput("rst_phase", a_phase, 32'd0);
    checkOutput("rst_busy", a_busy, 32'd0);
    checkOutput("rst_valid", a_valid, 32'd0);

    // Quarter-turn delta on ch0: four ticks walk the phase round once
    applyStimulus(0, 0, 1, 3'd0, 32'h4000_0000, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
      idle();
      settle();
      checkOutput("t1_ch", a_ch, 32'd0);
      checkOutput("t1_phase", a_phase, exp1[i]);
      checkOutput("t1_wrap", a_wrap, (i == 3) ? 32'd1 : 32'd0);
      repeat (6) idle();
    end

    // Distinct deltas, single sweep with exact latency
    applyStimulus(1, 0, 0, 3'd0, 32'd0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 3'(k), 32'(k + 1), 0);
    applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
    settle();
    checkOutput("t2_pre_valid", a_valid, 32'd0);
    checkOutput("t2_pre_busy", a_busy, 32'd1);
    for (int k = 0; k < 4; k++) begin
      idle();
      settle();
      checkOutput("t2_valid", a_valid, 32'd1);
      checkOutput("t2_ch", a_ch, 32'(k));
      checkOutput("t2_phase", a_phase, 32'(k + 1));
    end
    idle();
    settle();
    checkOutput("t2_post_valid", a_valid, 32'd0);

    // Back-to-back sweeps, then a dropped tick
    for (int s = 0; s < 3; s++) begin
      applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
      repeat (3) idle();
    end
    repeat (5) idle();
    applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
    idle();
    applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
    settle();
    checkOutput("t3_overrun", a_ovr, 32'd1);
    idle();
    settle();
    checkOutput("t3_overrun_end", a_ovr, 32'd0);
    repeat (4) idle();

    // Delta rewrite during its own channel's accumulate uses the old value
    applyStimulus(1, 0, 0, 3'd0, 32'd0, 0);
    applyStimulus(0, 0, 1, 3'd2, 32'h10, 0);
    applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
    repeat (2) idle();
    applyStimulus(0, 0, 1, 3'd2, 32'h20, 0);
    settle();
    checkOutput("t4_ch", a_ch, 32'd2);
    checkOutput("t4_old", a_phase, 32'h10);
    repeat (2) idle();
    applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
    repeat (3) idle();
    settle();
    checkOutput("t4_new", a_phase, 32'h30);
    repeat (3) idle();

    // Clear on the channel being accumulated, then out-of-range write on the wide build
    applyStimulus(1, 0, 0, 3'd0, 32'd0, 0);
    applyStimulus(0, 0, 1, 3'd1, 32'h100, 0);
    applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
    idle();
    applyStimulus(0, 0, 0, 3'd1, 32'd0, 1);
    settle();
    checkOutput("t5_clr_phase", a_phase, 32'd0);
    checkOutput("t5_clr_wrap", a_wrap, 32'd0);
    checkOutput("t5_clr_valid", a_valid, 32'd1);
    repeat (3) idle();
    applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
    repeat (2) idle();
    settle();
    checkOutput("t5_after_clr", a_phase, 32'h100);
    repeat (3) idle();
    applyStimulus(0, 0, 1, 3'd5, 32'hABC, 0);
    applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
    repeat (2) idle();
    settle();
    checkOutput("t5_wide_ignored", b_phase, 32'h200);
    checkOutput("t5_narrow_alias", a_phase, 32'hBBC);
    repeat (3) idle();

    // Reset in the middle of a sweep
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 3'(k), 32'(17 * (k + 1)), 0);
    applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
    repeat (2) idle();
    applyStimulus(1, 0, 0, 3'd0, 32'd0, 0);
    settle();
    checkOutput("t6_valid", a_valid, 32'd0);
    checkOutput("t6_busy", a_busy, 32'd0);
    checkOutput("t6_phase", a_phase, 32'd0);
    checkOutput("t6_ch", a_ch, 32'd0);
    applyStimulus(0, 1, 0, 3'd0, 32'd0, 0);
    idle();
    settle();
    checkOutput("t6_restart", a_phase, 32'd0);
    repeat (4) idle();

    // Random traffic against the model
    repeat (3000) begin
      applyStimulus(($urandom_range(199) == 0), ($urandom_range(2) == 0),
                    ($urandom_range(3) == 0), 3'($urandom_range(7)), $urandom,
                    ($urandom_range(9) == 0));
    end
    repeat (6) idle();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
